// File: rtl/aes_128_pipe_if.sv
// Data bundle for the free-running AES-128 pipeline: plaintext and key in,
// ciphertext out. There is no handshake; every clock carries a block.
interface aes_128_pipe_if;
    logic [127:0] state_i;
    logic [127:0] key_i;
    logic [127:0] out_o;

    // Upstream driver: supplies plaintext/key, observes ciphertext
    modport master (
        output state_i,
        output key_i,
        input  out_o
    );

    // Encryption core side
    modport slave (
        input  state_i,
        input  key_i,
        output out_o
    );
endinterface

// File: rtl/aes_128_pipe.sv
// Fully pipelined AES-128 encryptor. Stage 0 registers the key and the
// initial AddRoundKey; each of the 10 rounds then takes two stages:
// stage A expands the round key (data waits in a delay register), stage B
// computes the round output. Every block carries its own key down the pipe,
// so a new key/plaintext pair may be applied on every clock. Latency is 21
// capturing edges, counting the sampling edge.
module aes_128_pipe (
    input  logic           clk,
    input  logic           rst,
    aes_128_pipe_if.slave  bus
);

    // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) general multiply, shift-and-add
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? (p ^ aa) : p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (b^254, with 0 -> 0) then affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] base;
        logic [7:0] e;
        inv  = 8'h01;
        base = b;
        e    = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            inv  = e[i] ? gf_mul(inv, base) : inv;
            base = gf_mul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for round r (1..10), top byte of the word
    function automatic logic [7:0] rcon(input int r);
        logic [7:0] rc;
        case (r)
            1:       rc = 8'h01;
            2:       rc = 8'h02;
            3:       rc = 8'h04;
            4:       rc = 8'h08;
            5:       rc = 8'h10;
            6:       rc = 8'h20;
            7:       rc = 8'h40;
            8:       rc = 8'h80;
            9:       rc = 8'h1b;
            10:      rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One AES-128 key-schedule step: previous round key -> next round key
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3;
        logic [31:0] rw;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        w3 = k[31:0];
        rw = {w3[23:0], w3[31:24]};
        n0 = k[127:96] ^ {sbox(rw[31:24]) ^ rc, sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // SubBytes fused with ShiftRows; byte index is row + 4*column
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] t;
        t = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
        return t;
    endfunction

    // MixColumns over the four 32-bit columns
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        t = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            t[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return t;
    endfunction

    // Full round; the final round skips MixColumns
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = sub_shift(s);
        t = last ? t : mix_columns(t);
        return t ^ k;
    endfunction

    // Index 0 of key_b_q/st_b_q is the stage-0 input register (k0/s0);
    // index r is the stage-B register of round r. st_b_q[10] drives out.
    logic [127:0] key_b_q [0:9];
    logic [127:0] st_b_q  [0:10];
    logic [127:0] key_a_q [1:10];
    logic [127:0] dat_a_q [1:10];
    logic [127:0] key_a_d [1:10];
    logic [127:0] st_b_d  [1:10];

    // Round-key expansion for stage A and round datapath for stage B
    always_comb begin
        for (int r = 1; r <= 10; r++) begin
            key_a_d[r] = key_expand(key_b_q[r-1], rcon(r));
            st_b_d[r]  = aes_round(dat_a_q[r], key_a_q[r], r == 10);
        end
    end

    // Pipeline registers; every clock advances every stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r <= 9; r++) begin
                key_b_q[r] <= 128'h0;
            end
            for (int r = 0; r <= 10; r++) begin
                st_b_q[r] <= 128'h0;
            end
            for (int r = 1; r <= 10; r++) begin
                key_a_q[r] <= 128'h0;
                dat_a_q[r] <= 128'h0;
            end
        end else begin
            key_b_q[0] <= bus.key_i;
            st_b_q[0]  <= bus.state_i ^ bus.key_i;
            for (int r = 1; r <= 10; r++) begin
                key_a_q[r] <= key_a_d[r];
                dat_a_q[r] <= st_b_q[r-1];
                st_b_q[r]  <= st_b_d[r];
            end
            for (int r = 1; r <= 9; r++) begin
                key_b_q[r] <= key_a_q[r];
            end
        end
    end

    assign bus.out_o = st_b_q[10];

endmodule

// File: tb/tb_aes_128_pipe.sv
// Scoreboard bench for aes_128_pipe: each driven block pushes its expected
// ciphertext with the edge at which it must appear; a monitor pops and
// compares after every rising edge.
module tb_aes_128_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;

    aes_128_pipe_if bus ();

    aes_128_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [127:0] exp;
        string        tag;
    } exp_t;

    exp_t sb_q [$];
    int   checks    = 0;
    int   failures  = 0;
    int   edge_cnt  = 0;

    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] r_sb(input logic [7:0] b);
        return sbox_tbl[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] r_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int idx);
        case (idx)
            0:       return 8'h02;
            1:       return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    // Reference AES-128: full key schedule up front, byte-array state
    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   acc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {r_sb(tmp[23:16]), r_sb(tmp[15:8]), r_sb(tmp[7:0]), r_sb(tmp[31:24])}
                      ^ {rc, 24'h0};
                rc = r_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = r_sb(s[(i%4) + 4*(((i/4) + (i%4)) % 4)]);
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ r_mul(coef((j - r + 4) % 4), t[j + 4*c]);
                        s[r + 4*c] = acc;
                    end else begin
                        s[r + 4*c] = t[r + 4*c];
                    end
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] lfsr_next(input logic [127:0] s);
        return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
    endfunction

    // Drive one block on the next falling edge; it is sampled on the following rising edge
    task automatic drive(input string tag, input logic [127:0] pt, input logic [127:0] k,
                         input logic [127:0] ct);
        exp_t e;
        @(negedge clk);
        bus.state_i = pt;
        bus.key_i   = k;
        e.due = edge_cnt + 21;
        e.exp = ct;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: count edges, compare every block whose output edge has arrived
    always @(posedge clk) begin
        exp_t e;
        edge_cnt++;
        #1;
        while (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
            e = sb_q.pop_front();
            chk_eq(e.tag, bus.out_o, e.exp);
        end
    end

    logic [127:0] lf_s;
    logic [127:0] lf_k;
    logic [127:0] stale [$];
    int           lat_edge;
    int           first_due;
    logic         found;

    initial begin
        exp_t e;
        bus.state_i = 128'h0;
        bus.key_i   = 128'h0;
        #1 rst = 1'b1;
        #2 chk_eq("reset_async", bus.out_o, 128'h0);
        repeat (3) @(posedge clk);
        #1 chk_eq("reset_hold", bus.out_o, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single known-answer vector, with exact latency
        drive("kat_c1", C1_PT, C1_K, C1_CT);
        lat_edge = edge_cnt + 21;
        for (int i = 0; i < 24; i++) begin
            drive("kat_zero", 128'h0, 128'h0, Z_CT);
            if (edge_cnt == lat_edge - 1) chk_eq("c1_not_early", 128'(bus.out_o == C1_CT), 128'h0);
        end

        // Back-to-back vectors on consecutive edges
        drive("b2b_c1", C1_PT, C1_K, C1_CT);
        drive("b2b_b",  B_PT,  B_K,  B_CT);
        drive("b2b_z",  128'h0, 128'h0, Z_CT);
        drive("b2b_b2", B_PT,  B_K,  B_CT);

        // Random stream from two LFSRs
        lf_s = 128'h0123456789abcdeffedcba9876543210;
        lf_k = 128'hdeadbeefcafef00d5a5a5a5a13579bdf;
        for (int i = 0; i < 1100; i++) begin
            drive("rand", lf_s, lf_k, ref_aes(lf_s, lf_k));
            lf_s = lfsr_next(lf_s);
            lf_k = lfsr_next(lf_k);
        end

        // Mid-stream asynchronous reset with the pipeline full
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_eq("rst_mid_immediate", bus.out_o, 128'h0);
        stale.delete();
        foreach (sb_q[i]) stale.push_back(sb_q[i].exp);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 chk_eq("rst_mid_hold", bus.out_o, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.state_i = lf_s;
        bus.key_i   = lf_k;
        e.due = edge_cnt + 21;
        e.exp = ref_aes(lf_s, lf_k);
        e.tag = "post_rst_first";
        sb_q.push_back(e);
        first_due = e.due;
        for (int i = 0; i < 30; i++) begin
            lf_s = lfsr_next(lf_s);
            lf_k = lfsr_next(lf_k);
            drive("post_rst", lf_s, lf_k, ref_aes(lf_s, lf_k));
            if (edge_cnt < first_due) begin
                found = 1'b0;
                foreach (stale[j]) if (bus.out_o == stale[j]) found = 1'b1;
                chk_eq("no_stale_ct", 128'(found), 128'h0);
            end
        end

        // Drain and confirm every pushed block was compared
        for (int i = 0; i < 3; i++) drive("tail_c1", C1_PT, C1_K, C1_CT);
        repeat (23) @(posedge clk);
        #2 chk_eq("sb_drained", 128'(sb_q.size()), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
